// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: pops one byte, pulses TxInit, then waits
// for a TxDone rising edge. Define UART_TX_QUEUE_OVF_EN to get the sticky Overflow flag.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count,
  output logic        o_tx_init,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_done,
  output logic        o_overflow,
  input  logic        i_ovf_clr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_tx_data;
  logic          r_tx_done_q;
  state_t        r_state;

  state_t        w_state_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_tx_init;
  logic          w_done_rise;

  // Flags come straight from the count register; Full is the pre-edge value.
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_tx_data = r_tx_data;
  assign o_tx_init = w_tx_init;

  assign w_push      = i_wr_en & ~o_full;
  assign w_drop      = i_wr_en &  o_full;
  assign w_done_rise = i_tx_done & ~r_tx_done_q;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_init   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!o_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_tx_init   = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (w_done_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tx_data   <= 8'h00;
      r_tx_done_q <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_done_q <= i_tx_done;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

`ifdef UART_TX_QUEUE_OVF_EN
  logic r_overflow;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (i_ovf_clr) r_overflow <= 1'b0;
  end

  assign o_overflow = r_overflow;
`else
  logic w_unused_ovf;

  assign w_unused_ovf = i_ovf_clr | w_drop;
  assign o_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: latency, full/drop, ordering across wrap,
// TxDone level handling, reset mid-transfer and the overflow flag.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef UART_TX_QUEUE_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr_en, tx_done, ovf_clr;
  logic [7:0]  wr_data;
  logic        full, empty, tx_init, overflow;
  logic [AW:0] count;
  logic [7:0]  tx_data;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] got [$];

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_count(count), .o_tx_init(tx_init),
    .o_tx_data(tx_data), .i_tx_done(tx_done), .o_overflow(overflow),
    .i_ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // TxInit is a full-cycle pulse, so a negedge sample sees each launch once.
  always @(negedge clk) if (tx_init) got.push_back(tx_data);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // One-cycle TxDone pulse, then wait (bounded) for the next launch.
  task automatic pulse(output logic found);
    found   = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_init) begin
        found = 1'b1;
        break;
      end
    end
    if (found) tick();
  endtask

  initial begin
    int base;
    logic ok;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_txinit", 32'(tx_init), 0);
    chk("rst_txdata", 32'(tx_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;

    // single byte latency
    base = got.size();
    wr(8'hA5);
    chk("lat_count1", 32'(count), 1);
    chk("lat_init0", 32'(tx_init), 0);
    tick();
    chk("lat_init1", 32'(tx_init), 1);
    chk("lat_data", 32'(tx_data), 32'hA5);
    chk("lat_count0", 32'(count), 0);
    tick();
    chk("lat_init_off", 32'(tx_init), 0);
    repeat (5) tick();
    chk("lat_one_launch", 32'(got.size() - base), 1);
    chk("lat_empty", 32'(empty), 1);

    // fill to full, drop, overflow
    do_reset();
    base = got.size();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      tick();
      if (full) chk("fill_no_full", 32'(full), 0);
    end
    wr_en = 1'b0;
    chk("fill_count15", 32'(count), 15);
    chk("fill_full0", 32'(full), 0);
    chk("fill_txdata", 32'(tx_data), 0);
    wr(8'h10);
    chk("full_count16", 32'(count), 16);
    chk("full_flag", 32'(full), 1);
    wr(8'h11);
    chk("drop_count", 32'(count), 16);
    chk("drop_ovf", 32'(overflow), 32'(OVF));
    wr_en = 1'b1; ovf_clr = 1'b1; wr_data = 8'h12;
    tick();
    wr_en = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'(OVF));
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    chk("ovf_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      pulse(ok);
      chk("drain_launch", 32'(ok), 1);
    end
    pulse(ok);
    chk("drain_no_extra", 32'(ok), 0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_n", 32'(got.size() - base), 17);
    for (int i = 0; i < 17 && base + i < got.size(); i++)
      chk($sformatf("drain_order%0d", i), 32'(got[base+i]), 32'(i));

    // ordering across pointer wrap
    base = got.size();
    for (int i = 0; i < 10; i++) wr(8'h20 + 8'(i));
    tick();
    for (int i = 0; i < 5; i++) begin
      pulse(ok);
      chk("wrap_launch_a", 32'(ok), 1);
    end
    for (int i = 10; i < 20; i++) wr(8'h20 + 8'(i));
    chk("wrap_count", 32'(count), 14);
    for (int i = 0; i < 14; i++) begin
      pulse(ok);
      chk("wrap_launch_b", 32'(ok), 1);
    end
    pulse(ok);
    chk("wrap_no_extra", 32'(ok), 0);
    chk("wrap_n", 32'(got.size() - base), 20);
    for (int i = 0; i < 20 && base + i < got.size(); i++)
      chk($sformatf("wrap_order%0d", i), 32'(got[base+i]), 32'h20 + 32'(i));

    // TxDone held high
    do_reset();
    base = got.size();
    wr(8'hB1); wr(8'hB2); wr(8'hB3);
    tick(); tick();
    tx_done = 1'b1;
    repeat (10) tick();
    chk("lvl_n2", 32'(got.size() - base), 2);
    if (got.size() >= base + 2) chk("lvl_b2", 32'(got[base+1]), 32'hB2);
    tx_done = 1'b0;
    tick(); tick();
    tx_done = 1'b1;
    repeat (10) tick();
    chk("lvl_n3", 32'(got.size() - base), 3);
    if (got.size() >= base + 3) chk("lvl_b3", 32'(got[base+2]), 32'hB3);
    tx_done = 1'b0;
    tick(); tick();

    // reset while waiting, with bytes queued; writes ignored during reset
    do_reset();
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    repeat (3) tick();
    chk("mid_count5", 32'(count), 5);
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    rst_n = 1'b1; wr_en = 1'b0;
    chk("mid_count0", 32'(count), 0);
    chk("mid_empty", 32'(empty), 1);
    chk("mid_init", 32'(tx_init), 0);
    chk("mid_data", 32'(tx_data), 0);
    base = got.size();
    repeat (6) tick();
    chk("mid_quiet", 32'(got.size() - base), 0);
    wr(8'hD7);
    tick();
    chk("mid_new_init", 32'(tx_init), 1);
    chk("mid_new_data", 32'(tx_data), 32'hD7);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 WrEn  input  1  write strobe; one byte is accepted per cycle while high.
REQ-006 WrData  input  8  byte to enqueue.
REQ-007 Full  output  1  high when Count == DEPTH.
REQ-008 Empty  output  1  high when Count == 0.
REQ-009 Count  output  AW+1  number of stored bytes; excludes the byte handed to the transmitter.
REQ-010 TxInit  output  1  start pulse to the UART transmitter.
REQ-011 TxData  output  8  byte to the UART transmitter.
REQ-012 TxDone  input  1  transmitter completion indication; may be a pulse or a level.
REQ-013 Overflow  output  1  sticky flag for a dropped write.
REQ-014 OvfClr  input  1  clears Overflow.

Function
REQ-015 Storage SHALL be a circular buffer: wr_ptr and rd_ptr are AW bits wide and wrap from DEPTH-1 to 0.
REQ-016 A write with WrEn=1 and Full=0 SHALL store WrData at wr_ptr and increment wr_ptr and Count.
REQ-017 A write with WrEn=1 and Full=1 SHALL be dropped; pointers and Count SHALL be unchanged.
REQ-018 The Full test SHALL use the pre-edge value: a write while Full is dropped even if a pop occurs in the same cycle.
REQ-019 A simultaneous accepted write and pop SHALL leave Count unchanged.
REQ-020 The FSM SHALL have three states: IDLE, LAUNCH and WAIT_DONE.
REQ-021 IDLE with Empty=0: TxData <= mem[rd_ptr], rd_ptr++, Count--, next state LAUNCH.
REQ-022 IDLE with Empty=1: the FSM SHALL remain in IDLE.
REQ-023 LAUNCH: TxInit=1 for exactly this one cycle; next state WAIT_DONE.
REQ-024 WAIT_DONE SHALL leave on a TxDone rising edge (TxDone=1 while the registered previous TxDone=0) and return to IDLE.
REQ-025 A TxDone level already high on entry to WAIT_DONE SHALL NOT count as completion.
REQ-026 TxInit SHALL be 0 in IDLE and WAIT_DONE.
REQ-027 TxData SHALL be registered and stay stable from the pop until the next pop.
REQ-028 Latency: a write accepted at edge N into an empty, idle queue SHALL raise TxInit in the cycle after edge N+1.
REQ-029 Back-to-back bytes SHALL start at least 1 cycle after the qualifying TxDone edge: WAIT_DONE -> IDLE -> pop -> LAUNCH.
REQ-030 Full, Empty and Count SHALL be registered or derived only from registers, with no combinational path from WrEn.

Reset
REQ-031 Reset=0 at a clock edge SHALL force: state IDLE, wr_ptr=0, rd_ptr=0, Count=0, TxInit=0, TxData=8'h00, Overflow=0, previous-TxDone register=0.
REQ-032 Reset during LAUNCH or WAIT_DONE SHALL abandon the in-flight byte and discard all queued bytes; this block issues no abort to the transmitter.
REQ-033 WrEn SHALL be ignored while Reset=0.

Configuration
REQ-034 Macro UART_TX_QUEUE_OVF_EN SHALL control the overflow flag.
REQ-035 With the macro defined: a dropped write SHALL set Overflow at the next edge; OvfClr=1 SHALL clear it; a dropped write in the same cycle as OvfClr SHALL win (set has priority).
REQ-036 Without the macro: Overflow SHALL be tied 0, OvfClr ignored, no flag register synthesized; drop behaviour is unchanged.

Verification
REQ-037 Scenario: after reset, write 8'hA5 once, TxDone held 0 -> TxInit=1 for exactly 1 cycle, 2 cycles after the write; TxData=8'hA5; Count returns to 0; FSM stays in WAIT_DONE.
REQ-038 Scenario: write 16 bytes 8'h00..8'h0F with TxDone held 0 -> first byte popped; Count peaks at 15 and Full never asserts; writing 8'h10 then 8'h11 -> Full=1 and Count=16 after 8'h10; 8'h11 is dropped; Overflow=1 (with the macro).
REQ-039 Scenario: pulse TxDone for 1 cycle after each TxInit, 20 bytes queued across wrap-around -> all 20 bytes appear on TxData in write order, one TxInit per byte, no duplicates.
REQ-040 Scenario: TxDone held high continuously after a TxInit -> no further TxInit; a 0->1 transition then releases exactly one next byte.
REQ-041 Scenario: Reset=0 in WAIT_DONE with Count=5 -> next cycle Count=0, Empty=1, TxInit=0, TxData=8'h00, and no TxInit until a new write.
REQ-042 Scenario: with the macro, hold Full=1 and assert WrEn and OvfClr together -> Overflow=1; OvfClr alone on the next cycle -> Overflow=0.
